// File: rtl/picomips_pkg.sv
// picomips_pkg: shared types and constants for the picoMIPS switch-bus host.
//   host_state_t       host sequencer states, in sequence order
//   DEFAULT_DWELL      default cycles each SW8 phase is held
//   DEFAULT_RST_CYCLES default cycles the processor is held in reset
//   SW_NRST, SW_STB    bit positions of processor reset and strobe on SW
package picomips_pkg;

    localparam int DEFAULT_DWELL      = 32;
    localparam int DEFAULT_RST_CYCLES = 4;
    localparam int SW_NRST            = 9;
    localparam int SW_STB             = 8;

    typedef enum logic [3:0] {IDLE, PRST, PX, RX, PY, RY, PCAP, RCAP, FIN} host_state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

    // SW image for a state; PRST holds the processor in reset with a quiet bus,
    // IDLE and FIN release it with the strobe low and no data.
    function automatic logic [9:0] sw_encode(input host_state_t s, input logic [7:0] x,
                                             input logic [7:0] y);
        logic [9:0] sw;
        sw          = '0;
        sw[SW_NRST] = s != PRST;
        sw[SW_STB]  = s inside {PX, PY, PCAP};
        sw[7:0]     = (s inside {PX, RX}) ? x : (s inside {PY, RY}) ? y : 8'h00;
        return sw;
    endfunction

endpackage

// File: rtl/sw_handshake_host_if.sv
// sw_handshake_host_if: request/result and switch/LED bus between host and its user.
//   start, x_in, y_in   transaction request and operands
//   SW, LED             switch bus to / result bus from the processor
//   x_out, y_out        captured results
//   busy, done          sequencer status
interface sw_handshake_host_if;

    logic       start;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [7:0] LED;
    logic [9:0] SW;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic       busy;
    logic       done;

    modport master (input start, x_in, y_in, LED, output SW, x_out, y_out, busy, done);
    modport slave  (output start, x_in, y_in, LED, input SW, x_out, y_out, busy, done);

endinterface

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that stops at zero.
//   Clock, nReset  clock and asynchronous active-low reset
//   load           load load_value this cycle
//   load_value     value to load
//   expired        count is zero
module dwell_timer #(
    parameter int W = 6
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    // Saturates at zero so an idle timer never wraps.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = count == '0;

endmodule

// File: rtl/sw_handshake_host.sv
// sw_handshake_host: drives the picoMIPS processor through its switch bus,
// sending x then y with strobe phases and capturing the two LED results.
//   Clock, nReset  clock and asynchronous active-low reset
//   bus            sw_handshake_host_if master: start/x_in/y_in request,
//                  SW out / LED in, x_out/y_out results, busy/done status
module sw_handshake_host
    import picomips_pkg::*;
#(
    parameter int DWELL      = DEFAULT_DWELL,
    parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
    input  logic                Clock,
    input  logic                nReset,
    sw_handshake_host_if.master bus
);

    localparam int CW = cnt_width(DWELL, RST_CYCLES);

    host_state_t   state;
    host_state_t   state_n;
    logic          load;
    logic [CW-1:0] load_value;
    logic          expired;
    logic [7:0]    x_q;
    logic [7:0]    y_q;

    dwell_timer #(.W(CW)) u_timer (
        .Clock      (Clock),
        .nReset     (nReset),
        .load       (load),
        .load_value (load_value),
        .expired    (expired)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Timed states step to the next enum value when the timer reads zero.
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        load_value = CW'(DWELL - 1);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n    = PRST;
                    load       = 1'b1;
                    load_value = CW'(RST_CYCLES - 1);
                end
            end
            FIN: state_n = IDLE;
            default: begin
                if (expired) begin
                    state_n = host_state_t'(state + 4'd1);
                    load    = 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so SW, busy and done line up
    // with the state register and carry no combinational input path.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            x_q       <= '0;
            y_q       <= '0;
            bus.SW    <= '0;
            bus.x_out <= '0;
            bus.y_out <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                x_q <= bus.x_in;
                y_q <= bus.y_in;
            end
            if (state == RY && expired)
                bus.x_out <= bus.LED;
            if (state == RCAP && expired)
                bus.y_out <= bus.LED;
            bus.SW   <= sw_encode(state_n, x_q, y_q);
            bus.busy <= state_n != IDLE;
            bus.done <= state_n == FIN;
        end
    end

endmodule

// File: tb/tb_sw_handshake_host.sv
// tb_sw_handshake_host: randomized transactions against a processor stand-in,
// with a timeline model checking every output on every cycle.
module tb_sw_handshake_host;

    localparam int D    = 20;
    localparam int R    = 4;
    localparam int LAST = R + 6 * D + 1;

    logic Clock  = 1'b0;
    logic nReset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sw_handshake_host_if bus ();

    sw_handshake_host #(.DWELL(D), .RST_CYCLES(R)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    // Processor stand-in transform: x2 = 20 + x + y/4 + y/8, y2 = x - 20.
    function automatic logic [7:0] fx(input logic signed [7:0] x, input logic signed [7:0] y);
        int r;
        r = 20 + int'(x) + int'(y >>> 2) + int'(y >>> 3);
        return r[7:0];
    endfunction

    function automatic logic [7:0] fy(input logic signed [7:0] x);
        int r;
        r = int'(x) - 20;
        return r[7:0];
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Processor stand-in: counts strobe rises while out of reset,
    // takes x on the first, y on the second, shows x2 then y2 on LED.
    int         p_cnt;
    logic       p_prev;
    logic [7:0] p_x;

    always @(posedge Clock or negedge nReset) begin
        if (!nReset || !bus.SW[9]) begin
            p_cnt   <= 0;
            p_prev  <= 1'b0;
            bus.LED <= 8'h00;
        end else begin
            p_prev <= bus.SW[8];
            if (bus.SW[8] && !p_prev) begin
                p_cnt <= p_cnt + 1;
                if (p_cnt == 0) p_x <= bus.SW[7:0];
                if (p_cnt == 1) bus.LED <= fx(p_x, bus.SW[7:0]);
                if (p_cnt == 2) bus.LED <= fy(p_x);
            end
        end
    end

    // Timeline model: k counts cycles since the accepting edge (k=1 first reset cycle).
    bit         act = 1'b0;
    int         k   = 0;
    logic [7:0] mx  = '0;
    logic [7:0] my  = '0;
    logic [7:0] ex  = '0;
    logic [7:0] ey  = '0;

    always @(negedge nReset) begin
        act = 1'b0;
        ex  = '0;
        ey  = '0;
    end

    int         run       = 0;
    bit         seen_fall = 1'b0;
    logic       prev8     = 1'b0;
    int         p;
    logic [9:0] e_sw;
    logic       e_busy;
    logic       e_done;

    always @(posedge Clock) begin
        if (nReset) begin
            if (act) begin
                k++;
                if (k == R + 4 * D + 1) ex = fx(mx, my);
                if (k == LAST) ey = fy(mx);
                if (k > LAST) act = 1'b0;
            end else if (bus.start) begin
                act = 1'b1;
                k   = 1;
                mx  = bus.x_in;
                my  = bus.y_in;
            end
        end
        #1;
        if (!nReset) begin
            chk("rst_sw", 32'(bus.SW), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_x_out", 32'(bus.x_out), 0);
            chk("rst_y_out", 32'(bus.y_out), 0);
        end else begin
            if (!act) begin
                e_sw = 10'h200; e_busy = 1'b0; e_done = 1'b0;
            end else if (k <= R) begin
                e_sw = 10'h000; e_busy = 1'b1; e_done = 1'b0;
            end else if (k == LAST) begin
                e_sw = 10'h200; e_busy = 1'b1; e_done = 1'b1;
            end else begin
                p      = (k - R - 1) / D;
                e_sw   = {1'b1, p % 2 == 0, p < 2 ? mx : p < 4 ? my : 8'h00};
                e_busy = 1'b1;
                e_done = 1'b0;
            end
            chk("sw", 32'(bus.SW), 32'(e_sw));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("x_out", 32'(bus.x_out), 32'(ex));
            chk("y_out", 32'(bus.y_out), 32'(ey));
        end
        // Every strobe-high run, and every low run between two highs, lasts D cycles.
        if (!nReset || !bus.SW[9]) begin
            run = 0; seen_fall = 1'b0; prev8 = 1'b0;
        end else if (bus.SW[8] != prev8) begin
            if (prev8 || seen_fall) chk("phase_len", 32'(run), 32'(D));
            if (prev8) seen_fall = 1'b1;
            prev8 = bus.SW[8];
            run   = 1;
        end else begin
            run++;
        end
    end

    // One transaction; extra_at re-pulses start at that cycle count (0 = never).
    task automatic txn(input logic [7:0] x, input logic [7:0] y, input int extra_at, output int cyc);
        int c;
        @(negedge Clock);
        bus.start = 1'b1; bus.x_in = x; bus.y_in = y;
        c   = 1;
        cyc = -1;
        while (c < 400) begin
            @(negedge Clock);
            c++;
            if (bus.done) begin
                cyc = c;
                bus.start = 1'b0;
                break;
            end
            bus.start = (c == extra_at);
            bus.x_in  = 8'($urandom);
            bus.y_in  = 8'($urandom);
        end
        bus.start = 1'b0;
        if (cyc < 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout got no done want done within 400 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog");
    end

    int         cyc;
    logic [7:0] rx, ry;

    initial begin
        bus.start = 1'b0; bus.x_in = '0; bus.y_in = '0;
        #1 nReset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("reset_sw_lit", 32'(bus.SW), 32'h000);
        nReset = 1'b1;
        @(posedge Clock); #2;
        chk("first_sw_lit", 32'(bus.SW), 32'h200);

        txn(8'd10, 8'd20, 0, cyc);
        chk("latency_lit", 32'(cyc), 32'(2 + R + 6 * D));
        chk("x_lit_37", 32'(bus.x_out), 32'd37);
        chk("y_lit_m10", 32'(bus.y_out), 32'hF6);

        txn(8'd0, 8'd0, 0, cyc);
        chk("b2b_x_lit_20", 32'(bus.x_out), 32'd20);
        chk("b2b_y_lit_m20", 32'(bus.y_out), 32'hEC);

        txn(8'd10, 8'd20, R + 2 * D + 5, cyc);
        chk("py_start_latency", 32'(cyc), 32'(2 + R + 6 * D));
        chk("py_start_x", 32'(bus.x_out), 32'd37);
        @(negedge Clock);
        chk("single_done", 32'(bus.done), 0);

        @(negedge Clock);
        bus.start = 1'b1; bus.x_in = 8'd10; bus.y_in = 8'd20;
        @(negedge Clock);
        bus.start = 1'b0;
        repeat (R + D + 3) @(negedge Clock);
        #2 nReset = 1'b0;
        #1;
        chk("rx_reset_sw", 32'(bus.SW), 32'h000);
        chk("rx_reset_busy", 32'(bus.busy), 0);
        chk("rx_reset_x_out", 32'(bus.x_out), 0);
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        txn(8'd10, 8'd20, 0, cyc);
        chk("after_rst_x", 32'(bus.x_out), 32'd37);
        chk("after_rst_y", 32'(bus.y_out), 32'hF6);

        repeat (20) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            rx = 8'($urandom);
            ry = 8'($urandom);
            txn(rx, ry, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAST)) : 0, cyc);
            chk("rand_latency", 32'(cyc), 32'(2 + R + 6 * D));
            chk("rand_x_out", 32'(bus.x_out), 32'(fx(rx, ry)));
            chk("rand_y_out", 32'(bus.y_out), 32'(fy(rx)));
        end

        repeat (3) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_handshake_host.md
SW_HANDSHAKE_HOST -- requirements
Module: sw_handshake_host

Parameters
REQ-001 The block SHALL have parameter DWELL, default 32, giving the cycles each SW8 phase is held; legal values are 20 to 255.
REQ-002 The block SHALL have parameter RST_CYCLES, default 4, giving the cycles SW[9] is held low after a transaction starts.

Interface
REQ-003 Clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 nReset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to run one transaction; sampled in IDLE only.
REQ-006 x_in  in  8  signed operand x1, captured on accepted start.
REQ-007 y_in  in  8  signed operand y1, captured on accepted start.
REQ-008 LED  in  8  result bus from the processor.
REQ-009 SW  out  10  switch bus to the processor: SW[9] is processor nReset, SW[8] is the handshake strobe, SW[7:0] is data.
REQ-010 x_out  out  8  captured x2, held until the next capture.
REQ-011 y_out  out  8  captured y2, held until the next capture.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on the cycle y_out updates.

Function
REQ-014 The state machine SHALL have these states, in order: IDLE, PRST, PX, RX, PY, RY, PCAP, RCAP, FIN.
REQ-015 IDLE SHALL drive SW = 10'h200; start=1 SHALL latch x_in and y_in, load the counter, and enter PRST.
REQ-016 PRST SHALL drive SW[9]=0 for RST_CYCLES cycles, then enter PX.
REQ-017 In every state except PRST and IDLE, SW[9] SHALL be 1.
REQ-018 PX SHALL drive SW[8]=1 with SW[7:0]=x, and RX SHALL drive SW[8]=0 with SW[7:0]=x.
REQ-019 PY SHALL drive SW[8]=1 with SW[7:0]=y, and RY SHALL drive SW[8]=0 with SW[7:0]=y.
REQ-020 PCAP SHALL drive SW[8]=1, and RCAP SHALL drive SW[8]=0; SW[7:0] SHALL be 0 in both.
REQ-021 PX, RX, PY, RY, PCAP and RCAP SHALL each last exactly DWELL cycles.
REQ-022 The counter SHALL load DWELL-1 on state entry and advance the state on the cycle it reads 0.
REQ-023 x_out SHALL capture LED on the last cycle of RY; y_out SHALL capture LED on the last cycle of RCAP.
REQ-024 FIN SHALL last one cycle, assert done, and return to IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored.
REQ-026 SW SHALL come directly from registers, with no combinational path from any input.
REQ-027 The counter width SHALL be $clog2(max(DWELL,RST_CYCLES)+1), and the counter SHALL never wrap.

Reset
REQ-028 nReset low SHALL force, asynchronously: state IDLE, SW = 10'h000, x_out = y_out = 0, busy = done = 0, counter 0.
REQ-029 The first clock after nReset deasserts SHALL drive SW = 10'h200.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse and leave x_out and y_out at 0.

Structure
REQ-031 Shared package picomips_pkg SHALL hold the host_state_t enum, the default DWELL and RST_CYCLES values, and the SW bit-index constants (SW_NRST=9, SW_STB=8).
REQ-032 The dwell counter SHALL be sub-module dwell_timer, with ports load, load_value and expired.
REQ-033 The target implementation size is 120-250 lines of RTL in total.

Verification (bench instantiates the processor, with the host SW driving its SW and its LED driving the host LED)
REQ-034 start with x_in=10, y_in=20 -> done after 2+RST_CYCLES+6*DWELL cycles; x_out=8'd37 and y_out=8'hF6 (-10).
REQ-035 start with x_in=0, y_in=0 -> x_out=8'd20 and y_out=8'hEC (-20).
REQ-036 start pulsed again during PY -> exactly one done pulse and no change to the sequence timing.
REQ-037 nReset pulsed low during RX -> SW=10'h000 within the same cycle, busy=0, and no done; a following start with 10/20 still gives 37/-10.
REQ-038 Two back-to-back transactions (10/20, then 0/0) -> second done gives x_out=20 and y_out=-20.
REQ-039 Every run -> an assertion that SW[8] toggles only on state changes and that each phase is held exactly DWELL cycles.
